bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It sits upstream of the seven-segment digit decoders: it takes a raw binary value, typically a counter or HPS register, and produces packed 4-bit BCD digits. Each digit feeds one per-digit segment decoder. A start/busy/done handshake lets a controller sequence conversions without a combinational path from input to digits.

## Interface
- BIN_W, 16: width of binary input, 1..32.
- DIGITS, 5: number of BCD output digits, 1..10; digit 0 is least significant.
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  request conversion of bin_in; sampled only when busy=0.
- bin_in  in  BIN_W  value to convert; captured on accepted start.
- busy  out  1  conversion in progress.
- done  out  1  single-cycle pulse; bcd_out and overflow valid from this cycle.
- bcd_out  out  4*DIGITS  packed BCD result; digit k at bits [4k+3:4k]; held until next done.
- overflow  out  1  captured value exceeded 10^DIGITS-1; held with bcd_out.
- blank  out  DIGITS  leading-zero mask; bit k=1 means digit k should be blanked (see Configuration).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Reset (reset_n=0 at edge): state=IDLE, busy=0, done=0, bcd_out=0, overflow=0, blank=0, internal shift/count registers=0.
- IDLE/DONE with start=1:
  - capture bin_in into shift register, clear BCD accumulator, count=0, go to SHIFT, busy=1.
  - overflow_pending = (bin_in > 10^DIGITS-1).
- SHIFT, each cycle:
  - every accumulator digit >=5 gets +3 (4-bit, no carry between digits);
  - {accumulator, shift reg} shifts left 1; count++.
  - On the BIN_W-th shift: go to DONE and load outputs.
    - bcd_out = accumulator, or all digits 9 if overflow_pending.
    - overflow = overflow_pending.
- Accumulator width is 4*DIGITS; bits shifted past the top digit are discarded (only when overflow_pending).
- DONE lasts exactly one cycle (done=1). Without start, it returns to IDLE.
- start while busy=1 is ignored and not queued. bin_in changes during SHIFT have no effect.
- Reset mid-conversion aborts: no done pulse, outputs go to reset values.

## Timing
- Start accepted at edge E0. busy=1 in the cycle after E0 and stays high for exactly BIN_W cycles.
- done=1 in the following cycle: BIN_W+1 cycles after the accepting edge.
- bcd_out, overflow and blank update on the same edge that raises done, and are stable otherwise.
- Back-to-back: start=1 during the done cycle is accepted. The next done follows BIN_W+1 cycles later.
- Throughput: one conversion per BIN_W+1 cycles.
- No combinational path from any input to any output.

## Configuration
- Macro: BCD_LEADING_BLANK_EN.
- Defined:
  - blank bit k=1 iff digit k and all higher digits are 0, for k>=1.
  - Digit 0 is never blanked, so value 0 shows "0".
  - When overflow=1, blank=0.
- Undefined: blank is constant 0 and no blanking logic is generated.

## Structure
- Package bcd_pkg holds:
  - state typedef (IDLE, SHIFT, DONE);
  - function pow10_minus1(n) for the overflow limit;
  - constant BCD_NINE=4'h9.
- Sub-module bcd_add3: combinational per-digit correction, 4-bit in to 4-bit out (+3 when >=5). Instantiated DIGITS times via generate.
- Counter width is $clog2(BIN_W+1).

## Test plan
- Defaults, bin_in=0, start pulse:
  - busy high 16 cycles, done at cycle 17;
  - bcd_out=20'h00000, overflow=0.
- Defaults, bin_in=65535: bcd_out=20'h65535, overflow=0.
- DIGITS=4, bin_in=12345: overflow=1, bcd_out=16'h9999, blank=0.
- Defaults, bin_in=407, macro defined: bcd_out=20'h00407, blank=5'b11000. Macro undefined: blank=5'b00000.
- start held high during conversion of 100, with bin_in switched to 200:
  - exactly one done at cycle 17, bcd_out=20'h00100;
  - with start still high in the done cycle, a second conversion yields 20'h00200 at cycle 34.
- reset_n=0 at cycle 8 of a conversion of 999:
  - no done pulse; bcd_out=0, busy=0;
  - next start with 999 gives 20'h00999.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the sequential binary-to-BCD converter.
// Revision: 1.0
`default_nettype none

package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'h9;

    // Largest value representable in n BCD digits; 64 bits covers n up to 10.
    function automatic logic [63:0] pow10_minus1(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_add3.sv
// bcd_add3: per-digit double-dabble correction, adds 3 when the digit is 5 or more.
// Revision: 1.0
`default_nettype none

module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: one-bit-per-clock double-dabble converter with start/busy/done handshake.
// Optional leading-zero blanking via macro BCD_LEADING_BLANK_EN. Revision: 1.0
`default_nettype none

module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);

    localparam int                ACC_W = 4 * DIGITS;
    localparam int                CNT_W = $clog2(BIN_W + 1);
    localparam logic [63:0]       LIMIT = pow10_minus1(DIGITS);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(BIN_W - 1);

    state_t             state;
    state_t             state_next;
    logic [BIN_W-1:0]   shreg;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_shifted;
    logic [ACC_W-1:0]   result;
    logic [CNT_W-1:0]   count;
    logic               ovf_pending;
    logic               accept;
    logic               last_shift;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            bcd_add3 u_add3 (
                .din  (acc[4*i +: 4]),
                .dout (acc_adj[4*i +: 4])
            );
        end
    endgenerate

    // Bits leaving the top digit are dropped; that only happens on overflow.
    assign acc_shifted = {acc_adj[ACC_W-2:0], shreg[BIN_W-1]};
    assign result      = ovf_pending ? {DIGITS{BCD_NINE}} : acc_shifted;
    assign accept      = ((state == IDLE) || (state == DONE)) && start;
    assign last_shift  = (state == SHIFT) && (count == LAST);

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? SHIFT : IDLE;
            SHIFT:   state_next = (count == LAST) ? DONE : SHIFT;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shreg       <= '0;
            acc         <= '0;
            count       <= '0;
            ovf_pending <= 1'b0;
            bcd_out     <= '0;
            overflow    <= 1'b0;
        end else if (accept) begin
            shreg       <= bin_in;
            acc         <= '0;
            count       <= '0;
            ovf_pending <= (64'(bin_in) > LIMIT);
        end else if (state == SHIFT) begin
            shreg <= shreg << 1;
            acc   <= acc_shifted;
            count <= count + CNT_W'(1);
            if (last_shift) begin
                bcd_out  <= result;
                overflow <= ovf_pending;
            end
        end
    end

`ifdef BCD_LEADING_BLANK_EN
    logic [DIGITS-1:0] blank_next;
    logic              zero_above;

    // Scan from the top digit down; digit 0 always stays visible.
    always_comb begin
        blank_next = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above    = zero_above && (result[4*k +: 4] == 4'd0);
            blank_next[k] = zero_above && !ovf_pending;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            blank <= '0;
        end else if (last_shift) begin
            blank <= blank_next;
        end
    end
`else
    assign blank = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: randomized and directed checks of bin_to_bcd_seq against a decimal model.
// Revision: 1.0
`default_nettype none

module tb_bin_to_bcd_seq;

    localparam int BIN_W = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [BIN_W-1:0] bin_in = '0;

    logic        busy5, done5, ovf5;
    logic [19:0] bcd5;
    logic [4:0]  blank5;
    logic        busy4, done4, ovf4;
    logic [15:0] bcd4;
    logic [3:0]  blank4;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(5)) dut5 (
        .clk(clk), .reset_n(reset_n), .start(start), .bin_in(bin_in),
        .busy(busy5), .done(done5), .bcd_out(bcd5), .overflow(ovf5), .blank(blank5)
    );

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start), .bin_in(bin_in),
        .busy(busy4), .done(done4), .bcd_out(bcd4), .overflow(ovf4), .blank(blank4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint lim_of(input int d);
        longint p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p - 1;
    endfunction

    function automatic logic [39:0] model_bcd(input longint v, input int d);
        logic [39:0] r = '0;
        longint      x = v;
        for (int k = 0; k < d; k++) begin
            if (v > lim_of(d)) r[4*k +: 4] = 4'd9;
            else begin
                r[4*k +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
        return r;
    endfunction

    function automatic logic [9:0] model_blank(input longint v, input int d);
        logic [9:0] b = '0;
`ifdef BCD_LEADING_BLANK_EN
        if (v <= lim_of(d)) begin
            for (int k = 1; k < d; k++) b[k] = (v < lim_of(k) + 1);
        end
`endif
        return b;
    endfunction

    // Cycle-level reference: remaining busy cycles plus last published result.
    int          m_rem = 0;
    longint      m_cap = 0;
    bit          m_done = 1'b0;
    logic [19:0] m_bcd5 = '0;
    logic [15:0] m_bcd4 = '0;
    bit          m_ovf5 = 1'b0, m_ovf4 = 1'b0;
    logic [4:0]  m_blank5 = '0;
    logic [3:0]  m_blank4 = '0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_rem = 0; m_done = 1'b0;
            m_bcd5 = '0; m_bcd4 = '0; m_ovf5 = 1'b0; m_ovf4 = 1'b0;
            m_blank5 = '0; m_blank4 = '0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                logic [39:0] t5, t4;
                logic [9:0]  k5, k4;
                m_done = 1'b1;
                t5 = model_bcd(m_cap, 5);
                t4 = model_bcd(m_cap, 4);
                k5 = model_blank(m_cap, 5);
                k4 = model_blank(m_cap, 4);
                m_bcd5 = t5[19:0];
                m_bcd4 = t4[15:0];
                m_ovf5 = (m_cap > lim_of(5));
                m_ovf4 = (m_cap > lim_of(4));
                m_blank5 = k5[4:0];
                m_blank4 = k4[3:0];
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_rem = BIN_W;
                m_cap = longint'(bin_in);
            end
        end
        chk_en <= 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy5", busy5, m_rem > 0);
            chk("done5", done5, m_done);
            chk("bcd5", bcd5, m_bcd5);
            chk("ovf5", ovf5, m_ovf5);
            chk("blank5", blank5, m_blank5);
            chk("busy4", busy4, m_rem > 0);
            chk("done4", done4, m_done);
            chk("bcd4", bcd4, m_bcd4);
            chk("ovf4", ovf4, m_ovf4);
            chk("blank4", blank4, m_blank4);
        end
    end

    // Pulse start for one cycle, then count cycles after the accepting edge until done.
    task automatic conv(input logic [BIN_W-1:0] v, output int lat);
        @(negedge clk);
        start = 1'b1;
        bin_in = v;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done5 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!done5) begin
            errors++;
            $display("FAIL timeout: no done within %0d cycles", lat);
        end
    endtask

    logic [4:0] exp407_blank;

    initial begin
        int lat;
        int n;
        bit seen;

        repeat (3) @(negedge clk);
        chk("reset_bcd", bcd5, 20'h00000);
        chk("reset_busy", busy5, 1'b0);
        chk("reset_done", done5, 1'b0);
        reset_n = 1'b1;

        conv(16'd0, lat);
        chk("lat_zero", lat, 17);
        chk("lit_zero", bcd5, 20'h00000);
        chk("lit_zero_ovf", ovf5, 1'b0);

        conv(16'd65535, lat);
        chk("lit_65535", bcd5, 20'h65535);
        chk("lit_65535_ovf", ovf5, 1'b0);
        chk("lit_65535_ovf4", ovf4, 1'b1);

        conv(16'd12345, lat);
        chk("lit_d4_bcd", bcd4, 16'h9999);
        chk("lit_d4_ovf", ovf4, 1'b1);
        chk("lit_d4_blank", blank4, 4'b0000);

        conv(16'd407, lat);
        chk("lit_407", bcd5, 20'h00407);
`ifdef BCD_LEADING_BLANK_EN
        exp407_blank = 5'b11000;
`else
        exp407_blank = 5'b00000;
`endif
        chk("lit_407_blank", blank5, exp407_blank);

        // start held high; bin_in switched mid-conversion
        @(negedge clk);
        start = 1'b1;
        bin_in = 16'd100;
        @(negedge clk);
        bin_in = 16'd200;
        n = 1;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            if (done5) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        chk("held_first_cycle", n, 17);
        chk("held_first_bcd", bcd5, 20'h00100);
        @(negedge clk);
        start = 1'b0;
        n++;
        while (n < 60 && !done5) begin
            @(negedge clk);
            n++;
        end
        chk("held_second_cycle", n, 34);
        chk("held_second_bcd", bcd5, 20'h00200);

        // reset in the middle of a conversion
        @(negedge clk);
        start = 1'b1;
        bin_in = 16'd999;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (done5) seen = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_done", seen, 1'b0);
        chk("abort_bcd", bcd5, 20'h00000);
        chk("abort_busy", busy5, 1'b0);
        conv(16'd999, lat);
        chk("lit_999", bcd5, 20'h00999);

        // randomized traffic, including starts while busy and occasional resets
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            start = ($urandom % 3 == 0);
            case ($urandom % 6)
                0: bin_in = 16'd9999;
                1: bin_in = 16'd10000;
                2: bin_in = 16'd0;
                3: bin_in = 16'hFFFF;
                default: bin_in = 16'($urandom);
            endcase
            reset_n = ($urandom % 400 != 0);
        end
        @(negedge clk);
        start = 1'b0;
        reset_n = 1'b1;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
